// File: rtl/eth_rx_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : eth_rx_port_arbiter
//  Purpose  : Frame-granular round-robin merge of N MAC RX streams into one
//             64-bit AXI-Stream, tagged with source port, 2-entry skid buffer.
//  Revision : 1.0  initial release
// ============================================================================
module eth_rx_port_arbiter #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 64,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int ID_W    = $clog2(N_PORTS),
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_PORTS-1:0]        s_req,
    input  logic [N_PORTS*DATA_W-1:0] s_tdata,
    input  logic [N_PORTS*KEEP_W-1:0] s_tkeep,
    input  logic [N_PORTS-1:0]        s_tvalid,
    input  logic [N_PORTS-1:0]        s_tlast,
    output logic [N_PORTS-1:0]        s_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic [KEEP_W-1:0]         m_tkeep,
    output logic [ID_W-1:0]           m_tuser,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [N_PORTS*CNT_W-1:0]  stat_frames
);

    localparam int ENT_W = DATA_W + KEEP_W + 1 + ID_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         grant_q, grant_d;
    logic [ID_W-1:0]         rr_q, rr_d;
    logic [N_PORTS-1:0]      tready_q, tready_d;
    logic [1:0]              occ_q, occ_d;
    logic [1:0][ENT_W-1:0]   buf_q;

    logic                    w_found;
    logic [ID_W-1:0]         w_winner;
    logic [ID_W:0]           w_rr_sum;
    logic                    w_acc;
    logic                    w_acc_last;
    logic                    w_pop;
    logic [DATA_W-1:0]       w_in_data;
    logic [KEEP_W-1:0]       w_in_keep;
    logic                    w_in_last;
    logic [ENT_W-1:0]        w_new;

    assign w_in_data  = s_tdata[int'(grant_q) * DATA_W +: DATA_W];
    assign w_in_keep  = s_tkeep[int'(grant_q) * KEEP_W +: KEEP_W];
    assign w_in_last  = s_tlast[grant_q];
    assign w_acc      = (state_q == ST_XFER) && s_tvalid[grant_q] && tready_q[grant_q];
    assign w_acc_last = w_acc && w_in_last;
    assign w_pop      = (occ_q != 2'd0) && m_tready;
    assign w_new      = {w_in_data, w_in_keep, w_in_last, grant_q};

    // Round-robin search: first requester at or above the pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_rr_sum = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            w_rr_sum = {1'b0, rr_q} + (ID_W+1)'(k);
            if (w_rr_sum >= (ID_W+1)'(N_PORTS)) begin
                w_rr_sum = w_rr_sum - (ID_W+1)'(N_PORTS);
            end
            if (!w_found && s_req[w_rr_sum[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_rr_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    state_d = ST_XFER;
                    grant_d = w_winner;
                end
            end
            ST_XFER: begin
                if (w_acc_last) begin
                    state_d = ST_IDLE;
                    rr_d    = (grant_q == ID_W'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        case ({w_acc, w_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Ready is predicted from next-cycle occupancy so the buffer never overflows.
    always_comb begin
        tready_d = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            tready_d[i] = (state_d == ST_XFER) && (grant_d == ID_W'(i)) &&
                          (occ_d <= 2'd1) && !w_acc_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            tready_q <= '0;
            occ_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            tready_q <= tready_d;
            occ_q    <= occ_d;
        end
    end

    // Entry 0 is always the head; a push into a full buffer cannot occur.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
        end else begin
            case ({w_acc, w_pop})
                2'b10: buf_q[occ_q[0]] <= w_new;
                2'b01: buf_q[0] <= buf_q[1];
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        buf_q[0] <= w_new;
                    end else begin
                        buf_q[0] <= buf_q[1];
                        buf_q[1] <= w_new;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {m_tdata, m_tkeep, m_tlast, m_tuser} = buf_q[0];
    assign m_tvalid = (occ_q != 2'd0);
    assign s_tready = tready_q;

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_stat
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (w_acc_last && (grant_q == ID_W'(gi))) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
        assign stat_frames[gi*CNT_W +: CNT_W] = cnt_q;
    end

endmodule
`default_nettype wire
